// File: rtl/sd_pkg.sv
// Shared SD constants and the one-step CRC-7 (x^7 + x^3 + 1) remainder function.
package sd_pkg;

    localparam int          SD_CRC7_WIDTH = 7;
    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [6:0]  SD_CRC7_INIT  = 7'h00;

    // One message bit, MSB-first, no reflection or final inversion.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic inv;
        inv = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (inv ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_if.sv
// Bit-serial CRC-7 bus between the command host and sd_crc7.
// CRC_REF/MATCH exist only when SD_CRC7_MATCH_EN is defined.
interface sd_crc7_if;
    import sd_pkg::*;

    // No handshake: the bit in BITVAL is consumed on every rising edge where
    // Enable is high; CRC always shows the remainder of all bits consumed so far.
    logic                      BITVAL;
    logic                      Enable;
    logic [SD_CRC7_WIDTH-1:0]  CRC;
`ifdef SD_CRC7_MATCH_EN
    logic [SD_CRC7_WIDTH-1:0]  CRC_REF;
    logic                      MATCH;
`endif

    modport master (
        output BITVAL,
        output Enable,
`ifdef SD_CRC7_MATCH_EN
        output CRC_REF,
        input  MATCH,
`endif
        input  CRC
    );

    modport slave (
        input  BITVAL,
        input  Enable,
`ifdef SD_CRC7_MATCH_EN
        input  CRC_REF,
        output MATCH,
`endif
        output CRC
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC-7 generator/checker for the SD command path, one bit per enabled clock.
// Optional feature macro: SD_CRC7_MATCH_EN (adds CRC_REF compare and MATCH output).
module sd_crc7
    import sd_pkg::*;
#(
    parameter int                   CRC_WIDTH = SD_CRC7_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY      = SD_CRC7_POLY,
    parameter logic [CRC_WIDTH-1:0] INIT      = SD_CRC7_INIT
) (
    input  logic        CLK,
    input  logic        RST_N,
    sd_crc7_if.slave    bus
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_d;
    logic                 inv;

    assign inv = bus.BITVAL ^ crc_q[CRC_WIDTH-1];

    // Shift left; every tap set in POLY also takes the feedback bit.
    for (genvar k = 0; k < CRC_WIDTH; k++) begin : g_tap
        if (k == 0) begin : g_lsb
            assign crc_d[k] = inv & POLY[k];
        end else begin : g_upper
            assign crc_d[k] = crc_q[k-1] ^ (inv & POLY[k]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            crc_q <= INIT;
        end else if (bus.Enable) begin
            crc_q <= crc_d;
        end
    end

    assign bus.CRC = crc_q;

`ifdef SD_CRC7_MATCH_EN
    assign bus.MATCH = (crc_q == bus.CRC_REF);
`endif

endmodule

// File: tb/tb_sd_crc7.sv
// Directed bench for sd_crc7: reset, single bits, CMD0/CMD8/CMD17 frames, hold gaps.
module tb_sd_crc7;
    import sd_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    sd_crc7_if bus ();

    sd_crc7 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called at a negedge; applies inputs across one rising edge and returns at the next negedge.
    task automatic cyc(input logic rst_n, input logic en, input logic b);
        RST_N      = rst_n;
        bus.Enable = en;
        bus.BITVAL = b;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic shift_frame(input logic [39:0] frame, input bit gaps);
        for (int i = 39; i >= 0; i--) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                    cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            end
            cyc(1'b1, 1'b1, frame[i]);
        end
        bus.Enable = 1'b0;
    endtask

    initial begin
        logic [6:0]  model;
        logic [39:0] cmd0;
        checks     = 0;
        failures   = 0;
        RST_N      = 1'b0;
        bus.Enable = 1'b0;
        bus.BITVAL = 1'b0;
`ifdef SD_CRC7_MATCH_EN
        bus.CRC_REF = 7'h00;
`endif
        @(negedge CLK);

        // Reset with Enable and BITVAL high: reset must win every edge.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            check7("reset_hold", bus.CRC, 7'h00);
        end
`ifdef SD_CRC7_MATCH_EN
        check1("reset_match", bus.MATCH, 1'b1);
`endif
        cyc(1'b1, 1'b0, 1'b1);
        check7("reset_release", bus.CRC, 7'h00);

        cyc(1'b1, 1'b1, 1'b1);
        check7("single_one", bus.CRC, 7'h09);
        cyc(1'b1, 1'b1, 1'b0);
        check7("then_zero", bus.CRC, 7'h12);

        // Mid-frame reset discards the partial remainder.
        cyc(1'b0, 1'b1, 1'b1);
        check7("midframe_reset", bus.CRC, 7'h00);

        cmd0 = 40'h40_0000_0000;
        shift_frame(cmd0, 1'b0);
        check7("cmd0", bus.CRC, 7'h4A);

        // Enable low holds regardless of BITVAL.
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check7("hold", bus.CRC, 7'h4A);
`ifdef SD_CRC7_MATCH_EN
        bus.CRC_REF = 7'h4A;
        #1 check1("match_eq", bus.MATCH, 1'b1);
        bus.CRC_REF = 7'h4B;
        #1 check1("match_ne", bus.MATCH, 1'b0);
`endif

        cyc(1'b0, 1'b0, 1'b0);
        shift_frame(40'h48_0000_01AA, 1'b0);
        check7("cmd8", bus.CRC, 7'h43);

        cyc(1'b0, 1'b0, 1'b0);
        shift_frame(40'h51_0000_0000, 1'b0);
        check7("cmd17", bus.CRC, 7'h2A);

        cyc(1'b0, 1'b0, 1'b0);
        shift_frame(cmd0, 1'b1);
        check7("cmd0_gaps", bus.CRC, 7'h4A);

        // Package helper must agree with the hand-computed CMD0 value.
        model = SD_CRC7_INIT;
        for (int i = 39; i >= 0; i--) model = crc7_next(model, cmd0[i]);
        check7("pkg_cmd0", model, 7'h4A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
